// File: rtl/freq_gate_ctrl_pkg.sv
// Shared definitions for the frequency-meter gate sequencer: state encoding and
// the default range-select width.
package freq_gate_ctrl_pkg;

    localparam int MODE_W_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } gateState_t;

    function automatic logic isBusy(input gateState_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter shared by the gate window and the continuous-mode hold gap.
// `last` flags the final cycle of an interval (count == 1).
module gate_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clkControl,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             run,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clkControl) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (run && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer for the frequency meter: clear -> enable window -> latch, with
// per-range gate length, single-shot/continuous operation and abort on mode change.
module freq_gate_ctrl
    import freq_gate_ctrl_pkg::*;
#(
    parameter int MODE_W      = MODE_W_DEFAULT,
    parameter int CNT_W       = 24,
    parameter int GATE0       = 10,
    parameter int GATE1       = 100,
    parameter int GATE2       = 1000,
    parameter int GATE3       = 10000,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clkControl,
    input  logic              rst,
    input  logic [MODE_W-1:0] testMode,
    input  logic              modeControl,
    input  logic              start,
    output logic              enable,
    output logic              clear,
    output logic              latch,
    output logic              valid,
    output logic              busy,
    output logic [MODE_W-1:0] gateMode
);

    gateState_t        state;
    gateState_t        nextState;
    logic [MODE_W-1:0] oldMode;
    logic              oldModeControl;
    logic              modeChanged;
    logic [CNT_W-1:0]  gateLen;
    logic [CNT_W-1:0]  timerValue;
    logic              timerLoad;
    logic              timerRun;
    logic              timerLast;

    // Gate length follows the range captured at CLEAR, not the live input.
    always_comb begin
        gateLen = CNT_W'(GATE3);
        case (int'(oldMode))
            0:       gateLen = CNT_W'(GATE0);
            1:       gateLen = CNT_W'(GATE1);
            2:       gateLen = CNT_W'(GATE2);
            default: gateLen = CNT_W'(GATE3);
        endcase
    end

    assign timerLoad  = (state == CLEAR) || (state == LATCH);
    assign timerRun   = (state == GATE) || (state == HOLD);
    assign timerValue = (state == CLEAR) ? gateLen : CNT_W'(HOLD_CYCLES);

    gate_timer #(
        .CNT_W(CNT_W)
    ) uTimer (
        .clkControl(clkControl),
        .rst       (rst),
        .load      (timerLoad),
        .loadValue (timerValue),
        .run       (timerRun),
        .last      (timerLast)
    );

    assign modeChanged = (testMode != oldMode) || (modeControl != oldModeControl);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (modeControl || start) nextState = CLEAR;
            CLEAR:   nextState = GATE;
            GATE:    if (timerLast) nextState = LATCH;
            LATCH:   nextState = modeControl ? HOLD : IDLE;
            HOLD:    if (timerLast) nextState = CLEAR;
            default: nextState = IDLE;
        endcase
        // Abort overrides everything, including the final gate cycle.
        if ((state != IDLE) && modeChanged) begin
            nextState = modeControl ? CLEAR : IDLE;
        end
    end

    // Outputs are decoded from nextState so they are registered yet line up with the state.
    always_ff @(posedge clkControl) begin
        if (rst) begin
            state          <= IDLE;
            oldMode        <= '0;
            oldModeControl <= 1'b0;
            enable         <= 1'b0;
            clear          <= 1'b0;
            latch          <= 1'b0;
            valid          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state <= nextState;
            if (nextState == CLEAR) begin
                oldMode        <= testMode;
                oldModeControl <= modeControl;
            end
            enable <= (nextState == GATE);
            clear  <= (nextState == CLEAR);
            latch  <= (nextState == LATCH);
            valid  <= (nextState == LATCH);
            busy   <= isBusy(nextState);
        end
    end

    assign gateMode = oldMode;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl: directed stimulus pushes expected clear/window/valid
// events; a negedge monitor turns DUT strobes into events and compares them in order.
module tb_freq_gate_ctrl;

    localparam int EV_CLR = 0;
    localparam int EV_WIN = 1;
    localparam int EV_VLD = 2;

    typedef struct {
        int kind;
        int cyc;
        int arg;
    } ev_t;

    logic       clkControl = 1'b0;
    logic       rst        = 1'b1;
    logic [1:0] testMode   = 2'd0;
    logic       modeControl = 1'b0;
    logic       start      = 1'b0;
    logic       enable;
    logic       clear;
    logic       latch;
    logic       valid;
    logic       busy;
    logic [1:0] gateMode;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t expQ[$];

    freq_gate_ctrl dut (
        .clkControl (clkControl),
        .rst        (rst),
        .testMode   (testMode),
        .modeControl(modeControl),
        .start      (start),
        .enable     (enable),
        .clear      (clear),
        .latch      (latch),
        .valid      (valid),
        .busy       (busy),
        .gateMode   (gateMode)
    );

    always #5 clkControl = ~clkControl;

    always @(posedge clkControl) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expectEv(input int kind, input int c, input int arg);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.arg  = arg;
        expQ.push_back(e);
    endfunction

    function automatic void emit(input int kind, input int c, input int arg);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d arg=%0d, expected none", kind, c, arg);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.cyc != c || e.arg != arg) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d arg=%0d, expected kind=%0d cyc=%0d arg=%0d",
                         kind, c, arg, e.kind, e.cyc, e.arg);
            end
        end
    endfunction

    // Monitor: enable windows are reported as (first cycle, length) when enable falls.
    initial begin
        int  winStart;
        logic enPrev;
        winStart = 0;
        enPrev   = 1'b0;
        forever begin
            @(negedge clkControl);
            if (cyc > 0) begin
                check("exclusive", (int'(clear) + int'(enable) + int'(latch)) <= 1, 1);
                check("valid_eq_latch", int'(valid), int'(latch));
                if (enPrev && !enable) emit(EV_WIN, winStart, cyc - winStart);
                if (enable && !enPrev) winStart = cyc;
                if (clear) emit(EV_CLR, cyc, int'(gateMode));
                if (valid) emit(EV_VLD, cyc, int'(gateMode));
                enPrev = enable;
            end
        end
    end

    task automatic tickTo(input int target);
        while (cyc < target) @(negedge clkControl);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_clear"},  int'(clear),  0);
        check({tag, "_latch"},  int'(latch),  0);
        check({tag, "_valid"},  int'(valid),  0);
        check({tag, "_busy"},   int'(busy),   0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clkControl);
        checkIdleOutputs("reset");
        check("reset_gateMode", int'(gateMode), 0);
        rst = 1'b0;
        repeat (5) @(negedge clkControl);
        check("idle_single_busy", int'(busy), 0);

        // Single-shot, range 1, with an ignored start pulse mid-gate.
        testMode = 2'd1;
        start    = 1'b1;
        t        = cyc + 1;
        expectEv(EV_CLR, t, 1);
        expectEv(EV_WIN, t + 1, 100);
        expectEv(EV_VLD, t + 101, 1);
        @(negedge clkControl);
        start = 1'b0;
        tickTo(t + 50);
        check("gate_busy", int'(busy), 1);
        start = 1'b1;
        @(negedge clkControl);
        start = 1'b0;
        tickTo(t + 102);
        check("single_done_busy", int'(busy), 0);
        check("single_gateMode", int'(gateMode), 1);

        // Continuous, range 0: period 16, five measurements, then drop to single-shot in HOLD.
        testMode    = 2'd0;
        modeControl = 1'b1;
        t           = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            expectEv(EV_CLR, t + 16 * k, 0);
            expectEv(EV_WIN, t + 16 * k + 1, 10);
            expectEv(EV_VLD, t + 16 * k + 11, 0);
        end
        tickTo(t + 77);
        check("hold_busy", int'(busy), 1);
        modeControl = 1'b0;
        @(negedge clkControl);
        check("hold_abort_busy", int'(busy), 0);
        tickTo(t + 120);
        checkIdleOutputs("after_hold_abort");

        // Continuous, range 2 switched to range 3 mid-gate: abort and restart.
        testMode    = 2'd2;
        modeControl = 1'b1;
        t           = cyc + 1;
        expectEv(EV_CLR, t, 2);
        expectEv(EV_WIN, t + 1, 500);
        expectEv(EV_CLR, t + 501, 3);
        expectEv(EV_WIN, t + 502, 10000);
        expectEv(EV_VLD, t + 10502, 3);
        expectEv(EV_CLR, t + 10507, 3);
        expectEv(EV_WIN, t + 10508, 200);
        expectEv(EV_CLR, t + 10709, 3);
        tickTo(t + 500);
        testMode = 2'd3;
        tickTo(t + 600);
        check("abort_gateMode", int'(gateMode), 3);
        check("abort_enable", int'(enable), 1);

        // Reset during GATE, then restart and abort back to idle from CLEAR.
        tickTo(t + 10707);
        rst = 1'b1;
        @(negedge clkControl);
        checkIdleOutputs("mid_reset");
        check("mid_reset_gateMode", int'(gateMode), 0);
        rst = 1'b0;
        @(negedge clkControl);
        check("restart_clear", int'(clear), 1);
        modeControl = 1'b0;
        tickTo(t + 10730);
        checkIdleOutputs("final_idle");
        check("pending_events", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
